// File: rtl/tribus_xfer_seq.sv
// tribus_xfer_seq: break-before-make control sequencer for an sn74ls441 tridirectional bus transceiver.
// Defining TRIBUS_CAPTURE_EN adds the bus_in / cap_data / cap_vld capture path.
//
// state | meaning
// IDLE  | chip deselected, s=11, all G high; accepts or rejects req
// SETUP | cs low, source selected, all G high
// DRIVE | cs low, source held, destination G pins low
// TURN  | cs low, source held, all G high before release
module tribus_xfer_seq #(
  parameter int SETUP_CYC = 2,
  parameter int DRIVE_CYC = 4,
  parameter int TURN_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] src,
  input  logic [2:0] dst,
  input  logic       abort,
`ifdef TRIBUS_CAPTURE_EN
  input  logic [3:0] bus_in,
  output logic [3:0] cap_data,
  output logic       cap_vld,
`endif
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       cs,
  output logic       s1,
  output logic       s0,
  output logic       ga,
  output logic       gb,
  output logic       gc
);

  localparam int MAX_SD  = (SETUP_CYC > DRIVE_CYC) ? SETUP_CYC : DRIVE_CYC;
  localparam int MAX_CYC = (MAX_SD > TURN_CYC) ? MAX_SD : TURN_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LD = CNT_W'(DRIVE_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       src_q, src_nxt;
  logic [2:0]       dst_q, dst_nxt;
  logic             aborted_q, aborted_nxt;

  logic             cs_nxt, busy_nxt, done_nxt, err_nxt;
  logic [1:0]       s_nxt;
  logic [2:0]       g_nxt;
  logic [3:0]       dst_ext;
  logic             illegal;
  logic [2:0]       src_mask;
  logic             cnt_zero;

  // dst padded to four bits so src=3 indexes a defined (zero) bit
  assign dst_ext  = {1'b0, dst};
  assign illegal  = (src == 2'd3) || (dst == 3'b000) || dst_ext[src];
  assign cnt_zero = (cnt == '0);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    src_nxt     = src_q;
    dst_nxt     = dst_q;
    aborted_nxt = aborted_q;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (req && !busy) begin
          if (illegal) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt   = SETUP;
            cnt_nxt     = SETUP_LD;
            src_nxt     = src;
            dst_nxt     = dst;
            aborted_nxt = 1'b0;
          end
        end
      end
      SETUP: begin
        if (abort) begin
          state_nxt   = TURN;
          cnt_nxt     = TURN_LD;
          aborted_nxt = 1'b1;
        end else if (cnt_zero) begin
          state_nxt = DRIVE;
          cnt_nxt   = DRIVE_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_nxt   = TURN;
          cnt_nxt     = TURN_LD;
          aborted_nxt = 1'b1;
        end else if (cnt_zero) begin
          state_nxt = TURN;
          cnt_nxt   = TURN_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      TURN: begin
        if (cnt_zero) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          err_nxt   = aborted_q;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pin values are derived from the next state so every output is a flop.
  always_comb begin
    src_mask = {src_nxt == 2'd0, src_nxt == 2'd1, src_nxt == 2'd2};
    cs_nxt   = (state_nxt == IDLE);
    busy_nxt = (state_nxt != IDLE);
    s_nxt    = (state_nxt == IDLE) ? 2'b11 : src_nxt;
    g_nxt    = 3'b111;
    if (state_nxt == DRIVE) begin
      g_nxt = ~{dst_nxt[0], dst_nxt[1], dst_nxt[2]} | src_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      src_q     <= 2'b11;
      dst_q     <= 3'b000;
      aborted_q <= 1'b0;
      cs        <= 1'b1;
      s1        <= 1'b1;
      s0        <= 1'b1;
      ga        <= 1'b1;
      gb        <= 1'b1;
      gc        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      src_q          <= src_nxt;
      dst_q          <= dst_nxt;
      aborted_q      <= aborted_nxt;
      cs             <= cs_nxt;
      {s1, s0}       <= s_nxt;
      {ga, gb, gc}   <= g_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      err            <= err_nxt;
    end
  end

`ifdef TRIBUS_CAPTURE_EN
  logic cap_hit;

  // Last DRIVE cycle without abort; the transceiver inverts, so undo it here.
  assign cap_hit = (state == DRIVE) && !abort && cnt_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_data <= 4'b0000;
      cap_vld  <= 1'b0;
    end else begin
      cap_vld <= cap_hit;
      if (cap_hit) begin
        cap_data <= ~bus_in;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tribus_xfer_seq.sv
// Self-checking bench for tribus_xfer_seq: directed scenarios plus randomized transfers
// checked cycle by cycle against a phase-arithmetic reference model.
module tb_tribus_xfer_seq;

  localparam int S = 2;
  localparam int D = 4;
  localparam int T = 1;

  // {cs, s1, s0, ga, gb, gc, busy, done, err}
  localparam logic [8:0] IDLE_OUT = 9'b1_11_111_000;
  localparam logic [8:0] ERR_OUT  = 9'b1_11_111_001;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] src;
  logic [2:0] dst;
  logic       abort;
  logic       busy, done, err, cs, s1, s0, ga, gb, gc;
  logic [8:0] obs;
`ifdef TRIBUS_CAPTURE_EN
  logic [3:0] bus_in;
  logic [3:0] cap_data;
  logic       cap_vld;
  int         bus_force = -1;
`endif

  int checks = 0;
  int errors = 0;

  tribus_xfer_seq dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .src      (src),
    .dst      (dst),
    .abort    (abort),
`ifdef TRIBUS_CAPTURE_EN
    .bus_in   (bus_in),
    .cap_data (cap_data),
    .cap_vld  (cap_vld),
`endif
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cs       (cs),
    .s1       (s1),
    .s0       (s0),
    .ga       (ga),
    .gb       (gb),
    .gc       (gc)
  );

  always #5 clk = ~clk;

  assign obs = {cs, s1, s0, ga, gb, gc, busy, done, err};

  function automatic bit is_illegal(input logic [1:0] s, input logic [2:0] d);
    return (s == 2'd3) || (d == 3'd0) || (((int'(d) >> s) & 1) != 0);
  endfunction

  // phase: 0 setup, 1 drive, 2 turn, 3 done cycle
  function automatic logic [8:0] exp_out(input int phase, input logic [1:0] s,
                                         input logic [2:0] d, input bit ab);
    logic [2:0] g;
    g = 3'b111;
    if (phase == 3) return {1'b1, 2'b11, 3'b111, 1'b0, 1'b1, ab};
    if (phase == 1) g = ~{d[0], d[1], d[2]};
    return {1'b0, s, g, 1'b1, 2'b00};
  endfunction

  // Entered at the negedge of an IDLE cycle; returns at the negedge of an IDLE cycle
  // (the done cycle itself when hold=1, so the next request is sampled there).
  task automatic run_xfer(input logic [1:0] s, input logic [2:0] d,
                          input int abort_at, input bit hold);
    int         last_active, done_k, phase, k_end;
    bit         ab;
    logic [8:0] e;
    logic [1:0] ps;
    logic [2:0] pg;
`ifdef TRIBUS_CAPTURE_EN
    logic [3:0] bus_smp;
    bit         cap_exp;
    bus_smp = 4'h0;
`endif
    ab          = (abort_at != 0);
    last_active = ab ? abort_at : S + D;
    done_k      = last_active + T + 1;
    k_end       = hold ? done_k : done_k + 1;
    ps = 2'b11;
    pg = 3'b111;
    req   = 1'b1;
    src   = s;
    dst   = d;
    abort = 1'($urandom);
`ifdef TRIBUS_CAPTURE_EN
    bus_in = 4'($urandom);
`endif
    for (int k = 1; k <= k_end; k++) begin
      @(negedge clk);
      if (k <= last_active)          phase = (k <= S) ? 0 : 1;
      else if (k <= last_active + T) phase = 2;
      else if (k == done_k)          phase = 3;
      else                           phase = 4;
      e = (phase == 4) ? IDLE_OUT : exp_out(phase, s, d, ab);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL xfer_pins src=%0d dst=%b abort_at=%0d k=%0d: got %b expected %b",
                 s, d, abort_at, k, obs, e);
      end
      if ({s1, s0} != ps) begin
        checks++;
        if (pg !== 3'b111 || {ga, gb, gc} !== 3'b111) begin
          errors++;
          $display("FAIL s_change_g k=%0d: G before %b after %b, expected 111 both", k, pg, {ga, gb, gc});
        end
      end
      ps = {s1, s0};
      pg = {ga, gb, gc};
`ifdef TRIBUS_CAPTURE_EN
      cap_exp = !ab && (k == S + D + 1);
      checks++;
      if (cap_vld !== cap_exp) begin
        errors++;
        $display("FAIL cap_vld k=%0d: got %b expected %b", k, cap_vld, cap_exp);
      end
      if (cap_exp) begin
        checks++;
        if (cap_data !== ~bus_smp) begin
          errors++;
          $display("FAIL cap_data: got %b expected %b", cap_data, ~bus_smp);
        end
      end
      bus_in = 4'($urandom);
      if (k == S + D) begin
        if (bus_force >= 0) bus_in = 4'(bus_force);
        bus_smp = bus_in;
      end
`endif
      // Inputs are noise while busy: they must be ignored.
      src   = 2'($urandom);
      dst   = 3'($urandom);
      req   = (k < done_k) ? 1'($urandom) : ((k == done_k) && hold);
      abort = (k == abort_at) ? 1'b1 : ((k > last_active) ? 1'($urandom) : 1'b0);
    end
  endtask

  task automatic run_illegal(input logic [1:0] s, input logic [2:0] d);
    req   = 1'b1;
    src   = s;
    dst   = d;
    abort = 1'($urandom);
    @(negedge clk);
    checks++;
    if (obs !== ERR_OUT) begin
      errors++;
      $display("FAIL illegal_pulse src=%0d dst=%b: got %b expected %b", s, d, obs, ERR_OUT);
    end
    req   = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++;
      $display("FAIL illegal_after src=%0d dst=%b: got %b expected %b", s, d, obs, IDLE_OUT);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = 1'b0;
    src   = 2'd0;
    dst   = 3'd0;
    abort = 1'b0;
`ifdef TRIBUS_CAPTURE_EN
    bus_in = 4'h0;
`endif
    #12;
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs, IDLE_OUT);
    end
`ifdef TRIBUS_CAPTURE_EN
    checks++;
    if ({cap_data, cap_vld} !== 5'b0) begin
      errors++;
      $display("FAIL reset_cap: got %b expected 00000", {cap_data, cap_vld});
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs, IDLE_OUT);
    end
  endtask

  task automatic test_basic();
    run_xfer(2'd0, 3'b110, 0, 1'b0);
    run_xfer(2'd2, 3'b001, 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_illegal(2'd3, 3'b010);
    run_illegal(2'd0, 3'b001);
    run_illegal(2'd1, 3'b000);
    run_illegal(2'd2, 3'b100);
  endtask

  task automatic test_abort();
    run_xfer(2'd1, 3'b001, S + 2, 1'b0);
    run_xfer(2'd0, 3'b010, 1, 1'b0);
    run_xfer(2'd2, 3'b011, S + D, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_xfer(2'd2, 3'b011, 0, 1'b1);
    run_xfer(2'd2, 3'b011, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    req   = 1'b1;
    src   = 2'd0;
    dst   = 3'b110;
    abort = 1'b0;
    for (int k = 1; k <= S + 2; k++) begin
      @(negedge clk);
      req = 1'b0;
    end
    checks++;
    if ({ga, gb, gc} !== 3'b100) begin
      errors++;
      $display("FAIL mid_drive_g: got %b expected 100", {ga, gb, gc});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", obs, IDLE_OUT);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== IDLE_OUT) begin
      errors++;
      $display("FAIL after_reset_no_done: got %b expected %b", obs, IDLE_OUT);
    end
  endtask

`ifdef TRIBUS_CAPTURE_EN
  task automatic test_capture();
    bus_force = 14;
    run_xfer(2'd0, 3'b010, 0, 1'b0);
    bus_force = -1;
  endtask
`endif

  task automatic test_random();
    logic [1:0] s;
    logic [2:0] d;
    int         a;
    bit         h;
    for (int i = 0; i < 40; i++) begin
      s = 2'($urandom);
      d = 3'($urandom);
      if (is_illegal(s, d)) begin
        run_illegal(s, d);
      end else begin
        a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, S + D) : 0;
        h = (i < 39) && ($urandom_range(0, 1) == 1);
        run_xfer(s, d, a, h);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef TRIBUS_CAPTURE_EN
    test_capture();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
